// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: one-cycle request pulse with address,
// later answered by a single-cycle response carrying the instruction word.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// MIPS instruction-fetch stage: owns the PC, fetches one instruction at a time,
// holds it for decode until retire, then computes the next PC and refetches.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic        retire,
    pc_fetch_if.master  imem,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [1:0] NPC_PLUS4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH   = 2'b01;
    localparam logic [1:0] NPC_JUMP     = 2'b10;
    localparam logic [1:0] NPC_JUMP_REG = 2'b11;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic        instr_valid_r;
    logic        instr_valid_s;
    logic        imem_req_r;
    logic        imem_req_s;
    logic [31:0] imem_addr_r;
    logic [31:0] imem_addr_s;
    logic        fetch_err_r;
    logic        fetch_err_s;
    logic [31:0] instret_r;
    logic [31:0] instret_s;
    logic [31:0] npc_s;

    // Branch offsets are word-scaled and sign-extended; jumps keep the top
    // nibble of the sequential PC. All arithmetic wraps modulo 2^32.
    function automatic logic [31:0] next_pc(
        input logic [1:0]  op,
        input logic [31:0] cur_pc,
        input logic [31:0] ins,
        input logic [31:0] rs
    );
        logic [31:0] p4;
        p4 = cur_pc + 32'd4;
        case (op)
            NPC_PLUS4:    next_pc = p4;
            NPC_BRANCH:   next_pc = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
            NPC_JUMP:     next_pc = {p4[31:28], ins[25:0], 2'b00};
            NPC_JUMP_REG: next_pc = rs;
            default:      next_pc = p4;
        endcase
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instr_s       = instr_r;
        instr_valid_s = instr_valid_r;
        imem_req_s    = 1'b0;
        imem_addr_s   = imem_addr_r;
        fetch_err_s   = fetch_err_r;
        instret_s     = instret_r;
        npc_s         = next_pc(npc_op, pc_r, instr_r, rs_data);

        case (state_r)
            IDLE: begin
                state_s     = REQ;
                imem_req_s  = 1'b1;
                imem_addr_s = pc_r;
            end
            REQ: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    instr_s       = imem.imem_rdata;
                    instr_valid_s = 1'b1;
                    state_s       = HOLD;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (retire) begin
                    instret_s     = instret_r + 32'd1;
                    instr_valid_s = 1'b0;
                    if (npc_s[1:0] == 2'b00) begin
                        pc_s        = npc_s;
                        imem_addr_s = npc_s;
                        imem_req_s  = 1'b1;
                        state_s     = REQ;
                    end else begin
                        // Misaligned target: park without refetching.
                        fetch_err_s = 1'b1;
                        state_s     = ERR;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            ERR: begin
                state_s       = ERR;
                instr_valid_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered outputs and architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            instr_r       <= 32'd0;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= RESET_PC;
            fetch_err_r   <= 1'b0;
            instret_r     <= 32'd0;
        end else begin
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_valid_r <= instr_valid_s;
            imem_req_r    <= imem_req_s;
            imem_addr_r   <= imem_addr_s;
            fetch_err_r   <= fetch_err_s;
            instret_r     <= instret_s;
        end
    end

    assign imem.imem_req  = imem_req_r;
    assign imem.imem_addr = imem_addr_r;
    assign instr          = instr_r;
    assign instr_valid    = instr_valid_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_r + 32'd4;
    assign fetch_err      = fetch_err_r;
    assign instret        = instret_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized retire/fetch traffic
// compared against a plain-arithmetic next-PC reference model.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  npc_op;
    logic [31:0] rs_data;
    logic        retire;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic [31:0] instret;

    pc_fetch_if mif();

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .npc_op      (npc_op),
        .rs_data     (rs_data),
        .retire      (retire),
        .imem        (mif),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_instret;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic [31:0] p,
                                            input logic [31:0] ins, input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4  = p + 32'd4;
        off = int'($signed(ins[15:0]));
        case (op)
            2'd0:    return p4;
            2'd1:    return p4 + 32'(off * 4);
            2'd2:    return (p4 & 32'hF000_0000) | (32'({6'd0, ins[25:0]}) << 2);
            default: return rs;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0000_3000);
        chk({tag, "_pc_plus4"}, pc_plus4, 32'h0000_3004);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_req"}, {31'd0, mif.imem_req}, 32'd0);
        chk({tag, "_addr"}, mif.imem_addr, 32'h0000_3000);
        chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    // Act as instruction memory for one fetch; optional noise pulses retire
    // outside HOLD and rvalid outside WAIT.
    task automatic serve(input logic [31:0] addr, input int lat, input logic [31:0] data,
                         input bit noise);
        int n;
        n = 0;
        while (mif.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, mif.imem_req}, 32'd1);
        chk("req_addr", mif.imem_addr, addr);
        if (noise) begin
            retire  = 1'b1;
            npc_op  = 2'($urandom);
            rs_data = $urandom;
        end
        tick();
        chk("req_one_cycle", {31'd0, mif.imem_req}, 32'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
        end
        retire           = 1'b0;
        mif.imem_rvalid  = 1'b1;
        mif.imem_rdata   = data;
        chk("valid_before_resp", {31'd0, instr_valid}, 32'd0);
        tick();
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = $urandom;
        m_instr         = data;
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, data);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instret_hold", instret, m_instret);
        if (noise) begin
            mif.imem_rvalid = 1'b1;
            tick();
            mif.imem_rvalid = 1'b0;
            chk("instr_frozen", instr, m_instr);
        end
    endtask

    task automatic do_retire(input logic [1:0] op, input logic [31:0] rs);
        logic [31:0] npc;
        npc     = ref_npc(op, m_pc, m_instr, rs);
        npc_op  = op;
        rs_data = rs;
        retire  = 1'b1;
        tick();
        retire  = 1'b0;
        npc_op  = 2'($urandom);
        rs_data = $urandom;
        m_instret++;
        chk("retire_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("instret", instret, m_instret);
        if (npc[1:0] == 2'b00) begin
            m_pc = npc;
            chk("npc", pc, npc);
            chk("npc_req", {31'd0, mif.imem_req}, 32'd1);
            chk("npc_addr", mif.imem_addr, npc);
        end else begin
            chk("err_set", {31'd0, fetch_err}, 32'd1);
            chk("err_pc_held", pc, m_pc);
            chk("err_no_req", {31'd0, mif.imem_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int req_hits;
        rst             = 1'b1;
        retire          = 1'b0;
        npc_op          = 2'd0;
        rs_data         = 32'd0;
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = 32'd0;
        m_pc            = 32'h0000_3000;
        m_instr         = 32'd0;
        m_instret       = 32'd0;
        tick();
        tick();
        tick();
        check_reset("reset");

        // Reset release and first fetch.
        rst = 1'b0;
        tick();
        serve(32'h0000_3000, 0, 32'h2008_0005, 1'b0);

        // PLUS4 with a 3-cycle memory stall.
        do_retire(2'd0, 32'd0);
        chk("instret_one", instret, 32'd1);
        serve(32'h0000_3004, 3, 32'h0000_0000, 1'b0);

        // Backward and forward branches.
        do_retire(2'd0, 32'd0);
        serve(32'h0000_3008, 1, 32'h1000_FFFE, 1'b0);
        do_retire(2'd1, 32'd0);
        chk("branch_back", pc, 32'h0000_3004);
        serve(32'h0000_3004, 0, 32'h0000_0000, 1'b0);
        do_retire(2'd0, 32'd0);
        serve(32'h0000_3008, 2, 32'h1000_0003, 1'b0);
        do_retire(2'd1, 32'd0);
        chk("branch_fwd", pc, 32'h0000_3018);

        // Jump, jump-register, and PC wrap.
        serve(32'h0000_3018, 0, 32'h0000_0008, 1'b0);
        do_retire(2'd3, 32'h0000_3010);
        serve(32'h0000_3010, 0, 32'h0800_0C00, 1'b0);
        do_retire(2'd2, 32'd0);
        chk("jump", pc, 32'h0000_3000);
        serve(32'h0000_3000, 1, 32'h0000_0008, 1'b0);
        do_retire(2'd3, 32'h0000_3020);
        chk("jump_reg", pc, 32'h0000_3020);
        serve(32'h0000_3020, 0, 32'h0000_0000, 1'b0);
        do_retire(2'd3, 32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, 0, 32'h0000_0000, 1'b0);
        do_retire(2'd0, 32'd0);
        chk("wrap", pc, 32'h0000_0000);
        serve(32'h0000_0000, 0, 32'h0000_0000, 1'b0);

        // Randomized traffic with noise outside the accepting states.
        for (int k = 0; k < 40; k++) begin
            do_retire(2'($urandom), $urandom & 32'hFFFF_FFFC);
            serve(m_pc, int'($urandom_range(0, 3)), $urandom, 1'b1);
        end

        // Misaligned jump-register target parks in the error state.
        do_retire(2'd3, 32'h0000_3022);
        req_hits = 0;
        for (int i = 0; i < 10; i++) begin
            retire          = 1'b1;
            mif.imem_rvalid = 1'b1;
            tick();
            if (mif.imem_req === 1'b1 || instr_valid === 1'b1) req_hits++;
        end
        retire          = 1'b0;
        mif.imem_rvalid = 1'b0;
        chk("err_quiet", req_hits, 32'd0);
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("err_instret", instret, m_instret);
        rst = 1'b1;
        tick();
        check_reset("err_reset");

        // Reset in the middle of WAIT; late response must be discarded.
        rst = 1'b0;
        tick();
        chk("rewake_req", {31'd0, mif.imem_req}, 32'd1);
        mif.imem_rvalid = 1'b1;
        mif.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        mif.imem_rvalid = 1'b0;
        chk("rvalid_in_req_ignored", {31'd0, instr_valid}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        mif.imem_rvalid = 1'b1;
        tick();
        check_reset("midwait_reset");
        mif.imem_rvalid = 1'b0;
        rst       = 1'b0;
        m_pc      = 32'h0000_3000;
        m_instret = 32'd0;
        tick();
        serve(32'h0000_3000, 1, 32'h2008_0005, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
